// File: rtl/vga_sync_generator_pkg.sv
// Shared VGA timing defaults, phase encoding and sync bundle for the raster generator.
// Phase values are fixed because other display logic decodes them.
package vga_sync_generator_pkg;

  localparam int unsigned HVisibleDef  = 640;
  localparam int unsigned HFrontDef    = 16;
  localparam int unsigned HSyncDef     = 96;
  localparam int unsigned HBackDef     = 48;
  localparam int unsigned VVisibleDef  = 480;
  localparam int unsigned VFrontDef    = 10;
  localparam int unsigned VSyncDef     = 2;
  localparam int unsigned VBackDef     = 33;
  localparam int unsigned SyncDelayDef = 1;
  localparam int unsigned CountWidth   = 10;

  typedef enum logic [1:0] {
    PhActive = 2'd0,
    PhFront  = 2'd1,
    PhSync   = 2'd2,
    PhBack   = 2'd3
  } phase_e;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic video_on;
  } sync_t;

  localparam sync_t SyncIdle = '{hsync_n: 1'b1, vsync_n: 1'b1, video_on: 1'b0};

  // Phase that a given count falls in; segments are laid out ACTIVE, FRONT, SYNC, BACK.
  function automatic phase_e decode_phase(input logic [CountWidth-1:0] count,
                                          input int unsigned visible,
                                          input int unsigned front,
                                          input int unsigned sync);
    int unsigned c;
    c = 32'(count);
    if (c < visible) begin
      return PhActive;
    end else if (c < visible + front) begin
      return PhFront;
    end else if (c < visible + front + sync) begin
      return PhSync;
    end
    return PhBack;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with its registered phase FSM.
// The phase is loaded from the decode of the next count, so it can never drift from the counter.
module vga_axis_counter
  import vga_sync_generator_pkg::*;
#(
  parameter int unsigned VISIBLE = HVisibleDef,
  parameter int unsigned FRONT   = HFrontDef,
  parameter int unsigned SYNC    = HSyncDef,
  parameter int unsigned BACK    = HBackDef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  carry_in,
  output logic [CountWidth-1:0] count,
  output phase_e                phase,
  output logic                  carry_out
);

  localparam int unsigned Total = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [CountWidth-1:0] Last = CountWidth'(Total - 1);

  logic                  at_last;
  logic [CountWidth-1:0] count_next;

  always_comb begin
    at_last    = (count == Last);
    count_next = at_last ? '0 : count + CountWidth'(1);
    carry_out  = carry_in && at_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      phase <= PhActive;
    end else if (carry_in) begin
      count <= count_next;
      phase <= decode_phase(count_next, VISIBLE, FRONT, SYNC);
    end
  end

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: chained pixel/line counters, delayed sync/active outputs and strobes.
// Sync and active are pipelined so they line up with registered RGB downstream.
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = HVisibleDef,
  parameter int unsigned H_FRONT    = HFrontDef,
  parameter int unsigned H_SYNC     = HSyncDef,
  parameter int unsigned H_BACK     = HBackDef,
  parameter int unsigned V_VISIBLE  = VVisibleDef,
  parameter int unsigned V_FRONT    = VFrontDef,
  parameter int unsigned V_SYNC     = VSyncDef,
  parameter int unsigned V_BACK     = VBackDef,
  parameter int unsigned SYNC_DELAY = SyncDelayDef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pix_en,
  output logic [CountWidth-1:0] counter_x,
  output logic [CountWidth-1:0] counter_y,
  output logic                  hsync_n,
  output logic                  vsync_n,
  output logic                  video_on,
  output logic                  line_end,
  output logic                  frame_end
);

  phase_e hphase;
  phase_e vphase;
  logic   h_carry;
  logic   v_carry;
  sync_t  raw;
  sync_t  dly;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .carry_in (pix_en),
    .count    (counter_x),
    .phase    (hphase),
    .carry_out(h_carry)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .carry_in (h_carry),
    .count    (counter_y),
    .phase    (vphase),
    .carry_out(v_carry)
  );

  always_comb begin
    raw.hsync_n  = (hphase != PhSync);
    raw.vsync_n  = (vphase != PhSync);
    raw.video_on = (hphase == PhActive) && (vphase == PhActive);
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign dly = raw;
    end else begin : g_delay
      sync_t [SYNC_DELAY-1:0] pipe;
      sync_t [SYNC_DELAY:0]   chain;

      // chain[0] is the live decode; each enabled edge shifts it one stage deeper.
      assign chain = {pipe, raw};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe <= {SYNC_DELAY{SyncIdle}};
        end else if (pix_en) begin
          pipe <= chain[SYNC_DELAY-1:0];
        end
      end

      assign dly = pipe[SYNC_DELAY-1];
    end
  endgenerate

  assign hsync_n  = dly.hsync_n;
  assign vsync_n  = dly.vsync_n;
  assign video_on = dly.video_on;

  // Axis carries are exactly the enable-gated end-of-line / end-of-frame decodes.
  assign line_end  = h_carry;
  assign frame_end = v_carry;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Bench for vga_sync_generator: one default-timing instance plus small-timing instances
// with sync delays 0, 1 and 3, all driven by the same clock, reset and pix_en.
module tb_vga_sync_generator;

  localparam int unsigned SHV = 16, SHF = 3, SHS = 5, SHB = 4;
  localparam int unsigned SVV = 6,  SVF = 2, SVS = 2, SVB = 3;
  localparam int unsigned SHT = SHV + SHF + SHS + SHB;
  localparam int unsigned SVT = SVV + SVF + SVS + SVB;
  localparam int unsigned SFT = SHT * SVT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic [9:0] x_d, y_d, x_0, y_0, x_1, y_1, x_3, y_3;
  logic hs_d, vs_d, vo_d, le_d, fe_d;
  logic hs_0, vs_0, vo_0, le_0, fe_0;
  logic hs_1, vs_1, vo_1, le_1, fe_1;
  logic hs_3, vs_3, vo_3, le_3, fe_3;

  vga_sync_generator u_def (
    .clk(clk), .reset(reset), .pix_en(pix_en), .counter_x(x_d), .counter_y(y_d),
    .hsync_n(hs_d), .vsync_n(vs_d), .video_on(vo_d), .line_end(le_d), .frame_end(fe_d)
  );

  vga_sync_generator #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(0)
  ) u_s0 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .counter_x(x_0), .counter_y(y_0),
    .hsync_n(hs_0), .vsync_n(vs_0), .video_on(vo_0), .line_end(le_0), .frame_end(fe_0)
  );

  vga_sync_generator #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(1)
  ) u_s1 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .counter_x(x_1), .counter_y(y_1),
    .hsync_n(hs_1), .vsync_n(vs_1), .video_on(vo_1), .line_end(le_1), .frame_end(fe_1)
  );

  vga_sync_generator #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB), .SYNC_DELAY(3)
  ) u_s3 (
    .clk(clk), .reset(reset), .pix_en(pix_en), .counter_x(x_3), .counter_y(y_3),
    .hsync_n(hs_3), .vsync_n(vs_3), .video_on(vo_3), .line_end(le_3), .frame_end(fe_3)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       vo;
    logic       le;
    logic       fe;
  } obs_t;

  typedef struct {
    logic rst;
    logic en;
    int   x;
    int   y;
    int   hs;
    int   vs;
    int   vo;
    int   le;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned n = 0;  // enabled edges since the last reset
  obs_t        o_def, o_s0, o_s1, o_s3;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Position is just n folded over the frame; delayed outputs describe position n - d.
  function automatic obs_t model(input int unsigned cnt, input int unsigned hv,
                                 input int unsigned hf, input int unsigned hs,
                                 input int unsigned hb, input int unsigned vv,
                                 input int unsigned vf, input int unsigned vs,
                                 input int unsigned vb, input int unsigned d, input logic en);
    obs_t        r;
    int unsigned ht, vt, p, q, qx, qy;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    p    = cnt % (ht * vt);
    r.x  = 10'(p % ht);
    r.y  = 10'(p / ht);
    r.le = en && (p % ht == ht - 1);
    r.fe = r.le && (p / ht == vt - 1);
    if (cnt < d) begin
      r.hs = 1'b1;
      r.vs = 1'b1;
      r.vo = 1'b0;
    end else begin
      q    = (cnt - d) % (ht * vt);
      qx   = q % ht;
      qy   = q / ht;
      r.hs = !(qx >= hv + hf && qx < hv + hf + hs);
      r.vs = !(qy >= vv + vf && qy < vv + vf + vs);
      r.vo = (qx < hv) && (qy < vv);
    end
    return r;
  endfunction

  task automatic check_obs(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".counter_x"}, int'(a.x), int'(e.x));
    chk({tag, ".counter_y"}, int'(a.y), int'(e.y));
    chk({tag, ".hsync_n"}, int'(a.hs), int'(e.hs));
    chk({tag, ".vsync_n"}, int'(a.vs), int'(e.vs));
    chk({tag, ".video_on"}, int'(a.vo), int'(e.vo));
    chk({tag, ".line_end"}, int'(a.le), int'(e.le));
    chk({tag, ".frame_end"}, int'(a.fe), int'(e.fe));
  endtask

  task automatic sample();
    o_def = {x_d, y_d, hs_d, vs_d, vo_d, le_d, fe_d};
    o_s0  = {x_0, y_0, hs_0, vs_0, vo_0, le_0, fe_0};
    o_s1  = {x_1, y_1, hs_1, vs_1, vo_1, le_1, fe_1};
    o_s3  = {x_3, y_3, hs_3, vs_3, vo_3, le_3, fe_3};
  endtask

  task automatic check_all();
    check_obs("def", o_def, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1, pix_en));
    check_obs("s0", o_s0, model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 0, pix_en));
    check_obs("s1", o_s1, model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1, pix_en));
    check_obs("s3", o_s3, model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 3, pix_en));
  endtask

  // Drive just after a rising edge, sample on the falling edge, then advance the model.
  task automatic step(input logic rst, input logic en);
    reset  = rst;
    pix_en = en;
    if (rst) n = 0;
    @(negedge clk);
    sample();
    check_all();
    @(posedge clk);
    if (!rst && en) n++;
    #1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[11];
    int   t656, tfall, low_run, width, le_cnt, le_bad, wrap_pending;
    int   fe_t[$];
    int   t_start, fall0, fall1, fall3, vo_cnt, vs_cnt, vs_bad, prev_y;
    int   strobe_off, hold_bad, found;
    obs_t prev;
    logic prev_hs0, prev_hs1, prev_hs3, prev_hs, prev_en;

    // Reset and first cycles on the default-timing instance.
    for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b1, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1'b0, 1'b1, 1, 0, 1, 1, 1, 0};
    tbl[7]  = '{1'b0, 1'b0, 2, 0, 1, 1, 1, 0};
    tbl[8]  = '{1'b0, 1'b0, 2, 0, 1, 1, 1, 0};
    tbl[9]  = '{1'b0, 1'b1, 2, 0, 1, 1, 1, 0};
    tbl[10] = '{1'b0, 1'b1, 3, 0, 1, 1, 1, 0};
    for (int i = 0; i < 11; i++) begin
      reset  = tbl[i].rst;
      pix_en = tbl[i].en;
      @(negedge clk);
      sample();
      chk($sformatf("tbl%0d.counter_x", i), int'(o_def.x), tbl[i].x);
      chk($sformatf("tbl%0d.counter_y", i), int'(o_def.y), tbl[i].y);
      chk($sformatf("tbl%0d.hsync_n", i), int'(o_def.hs), tbl[i].hs);
      chk($sformatf("tbl%0d.vsync_n", i), int'(o_def.vs), tbl[i].vs);
      chk($sformatf("tbl%0d.video_on", i), int'(o_def.vo), tbl[i].vo);
      chk($sformatf("tbl%0d.line_end", i), int'(o_def.le), tbl[i].le);
      @(posedge clk);
      #1;
    end

    // One full default line and a bit.
    step(1'b1, 1'b1);
    t656 = -1; tfall = -1; low_run = 0; width = -1; le_cnt = 0; le_bad = 0;
    wrap_pending = 0; prev_hs = 1'b1;
    for (int c = 0; c < 1700; c++) begin
      step(1'b0, 1'b1);
      if (wrap_pending == 1) begin
        chk("line.wrap_x", int'(o_def.x), 0);
        chk("line.wrap_y", int'(o_def.y), 1);
        wrap_pending = 2;
      end
      if (o_def.x == 10'd656 && t656 < 0) t656 = c;
      if (prev_hs && !o_def.hs) begin
        if (tfall < 0) tfall = c;
        low_run = 0;
      end
      if (!o_def.hs) low_run++;
      if (!prev_hs && o_def.hs && width < 0) width = low_run;
      if (o_def.le) begin
        le_cnt++;
        if (o_def.x != 10'd799) le_bad++;
        if (wrap_pending == 0) wrap_pending = 1;
      end
      prev_hs = o_def.hs;
    end
    chk("line.hsync_fall_delay", tfall - t656, 1);
    chk("line.hsync_width", width, 96);
    chk("line.line_end_count", le_cnt, 2);
    chk("line.line_end_off_799", le_bad, 0);

    // Small-timing frames with pix_en held high.
    step(1'b1, 1'b1);
    fe_t.delete();
    t_start = -1; fall0 = -1; fall1 = -1; fall3 = -1;
    vo_cnt = 0; vs_cnt = 0; vs_bad = 0; prev_y = 0;
    prev_hs0 = 1'b1; prev_hs1 = 1'b1; prev_hs3 = 1'b1;
    for (int c = 0; c < int'(3 * SFT + 10); c++) begin
      step(1'b0, 1'b1);
      if (o_s1.x == 10'(SHV + SHF) && t_start < 0) t_start = c;
      if (prev_hs0 && !o_s0.hs && fall0 < 0) fall0 = c;
      if (prev_hs1 && !o_s1.hs && fall1 < 0) fall1 = c;
      if (prev_hs3 && !o_s3.hs && fall3 < 0) fall3 = c;
      prev_hs0 = o_s0.hs; prev_hs1 = o_s1.hs; prev_hs3 = o_s3.hs;
      if (fe_t.size() == 1) begin
        if (o_s1.vo) vo_cnt++;
        if (!o_s1.vs) begin
          vs_cnt++;
          if (prev_y < int'(SVV + SVF) || prev_y >= int'(SVV + SVF + SVS)) vs_bad++;
        end
      end
      prev_y = int'(o_s1.y);
      if (o_s1.fe) fe_t.push_back(c);
    end
    chk("frame.fe_count", fe_t.size(), 3);
    if (fe_t.size() >= 3) begin
      chk("frame.period0", fe_t[1] - fe_t[0], int'(SFT));
      chk("frame.period1", fe_t[2] - fe_t[1], int'(SFT));
    end
    chk("frame.video_on_cycles", vo_cnt, int'(SHV * SVV));
    chk("frame.vsync_low_cycles", vs_cnt, int'(SVS * SHT));
    chk("frame.vsync_outside_lines", vs_bad, 0);
    chk("delay0.hsync_fall", fall0 - t_start, 0);
    chk("delay1.hsync_fall", fall1 - t_start, 1);
    chk("delay3.hsync_fall", fall3 - t_start, 3);

    // Half-rate enable.
    step(1'b1, 1'b1);
    fe_t.delete();
    strobe_off = 0; hold_bad = 0; prev_en = 1'b1; prev = '0;
    for (int c = 0; c < int'(4 * SFT + 20); c++) begin
      step(1'b0, (c % 2) == 0);
      if (!pix_en && (o_s1.le || o_s1.fe || o_def.le || o_def.fe || o_s0.le || o_s3.fe))
        strobe_off++;
      if (!prev_en && (o_s1.x != prev.x || o_s1.y != prev.y || o_s1.hs != prev.hs ||
                       o_s1.vs != prev.vs || o_s1.vo != prev.vo))
        hold_bad++;
      if (o_s1.fe) fe_t.push_back(c);
      prev    = o_s1;
      prev_en = pix_en;
    end
    chk("half.strobe_while_disabled", strobe_off, 0);
    chk("half.hold_violations", hold_bad, 0);
    chk("half.fe_count_ge2", int'(fe_t.size() >= 2), 1);
    if (fe_t.size() >= 2) chk("half.frame_period", fe_t[1] - fe_t[0], int'(2 * SFT));

    // Reset asserted while both syncs are low.
    step(1'b1, 1'b1);
    found = 0;
    for (int c = 0; c < int'(SFT) && found == 0; c++) begin
      step(1'b0, 1'b1);
      if (o_s1.x == 10'(SHV + SHF + 2) && o_s1.y == 10'(SVV + SVF + 1)) found = 1;
    end
    chk("rst.position_reached", found, 1);
    chk("rst.hsync_low_before", int'(o_s1.hs), 0);
    chk("rst.vsync_low_before", int'(o_s1.vs), 0);
    reset = 1'b1;
    #1;
    chk("rst.hsync_n_immediate", int'(hs_1), 1);
    chk("rst.vsync_n_immediate", int'(vs_1), 1);
    chk("rst.hsync_n_immediate_d3", int'(hs_3), 1);
    chk("rst.counter_x_immediate", int'(x_1), 0);
    chk("rst.counter_y_immediate", int'(y_1), 0);
    n = 0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("rst.resume_x0", int'(o_s1.x), 0);
    step(1'b0, 1'b1);
    chk("rst.resume_x1", int'(o_s1.x), 1);

    // Random enable with occasional reset, checked against the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_generator.md
# vga_sync_generator

Produces VGA raster timing for the pong display: horizontal/vertical pixel counters, active-low hsync/vsync, a video-active flag, and line/frame strobes. It drives the `CounterX`/`CounterY` inputs of the colour controller and the board's sync pins. Its sync and active outputs are delayed to line up with the controller's registered RGB. Frame strobes let game logic update ball and paddle state once per frame, during vertical blanking.

## Interface
- `H_VISIBLE`, default 640: active pixels per line.
- `H_FRONT`, default 16: horizontal front porch, in pixels.
- `H_SYNC`, default 96: hsync width, in pixels.
- `H_BACK`, default 48: horizontal back porch, in pixels.
- `V_VISIBLE`, default 480: active lines per frame.
- `V_FRONT`, default 10: vertical front porch, in lines.
- `V_SYNC`, default 2: vsync width, in lines.
- `V_BACK`, default 33: vertical back porch, in lines.
- `SYNC_DELAY`, default 1: pipeline stages on `hsync_n`, `vsync_n` and `video_on`. Legal range is 0..3.
- `clk` in 1: pixel clock, 25 MHz.
- `reset` in 1: asynchronous, active-high.
- `pix_en` in 1: pixel advance enable. Tie high when `clk` is 25 MHz; pulse every other cycle when `clk` is 50 MHz.
- `counter_x` out 10: current pixel column. Feeds `CounterX`.
- `counter_y` out 10: current line. Feeds `CounterY`.
- `hsync_n` out 1: horizontal sync, active-low, delayed by `SYNC_DELAY`.
- `vsync_n` out 1: vertical sync, active-low, delayed by `SYNC_DELAY`.
- `video_on` out 1: high when the delayed pixel position is inside the visible area.
- `line_end` out 1: high while `counter_x == H_TOTAL-1` and `pix_en` is high.
- `frame_end` out 1: high while `counter_x == H_TOTAL-1`, `counter_y == V_TOTAL-1` and `pix_en` is high.

## Operation
- Totals: `H_TOTAL = sum(H_*)` = 800; `V_TOTAL = sum(V_*)` = 525. All arithmetic is unsigned 10-bit, and both totals must be ≤ 1024.
- Horizontal counter:
  - Increments on each `clk` edge where `pix_en` = 1.
  - At `H_TOTAL-1` it wraps to 0 and issues a carry to the vertical counter.
- Vertical counter:
  - Increments only on a horizontal carry.
  - At `V_TOTAL-1`, together with the carry, it wraps to 0.
- Per-axis phase FSM with states ACTIVE → FRONT → SYNC → BACK → ACTIVE. Each transition happens on the counter edge that crosses the boundary.
- Horizontal phase boundaries at defaults:
  - ACTIVE 0-639.
  - FRONT 640-655.
  - SYNC 656-751.
  - BACK 752-799.
- Vertical phase boundaries at defaults:
  - ACTIVE 0-479.
  - FRONT 480-489.
  - SYNC 490-491.
  - BACK 492-524.
- The FSM state is registered alongside its counter. It must always equal the decode of that counter, so there is no separate drift path.
- Undecoded sync/active values:
  - raw hsync_n = !(hstate == SYNC);
  - raw vsync_n = !(vstate == SYNC);
  - raw video_on = (hstate == ACTIVE && vstate == ACTIVE).
- The raw values pass through a `SYNC_DELAY`-deep shift register. It advances only when `pix_en` = 1. With `SYNC_DELAY` = 0 the outputs are the raw decodes.
- `line_end` and `frame_end` are combinational decodes of the registered counters gated by `pix_en`. They are used as enables by the game-state logic.
- When `pix_en` = 0 for any number of cycles, all counters, FSMs and pipeline stages hold.

## Timing
- Reset values, asserted asynchronously:
  - `counter_x` = 0 and `counter_y` = 0.
  - Both FSMs in ACTIVE.
  - Every delay stage holds `hsync_n` = 1, `vsync_n` = 1, `video_on` = 0.
  - `line_end` = 0 and `frame_end` = 0.
- First `pix_en` edge after reset deasserts: counters go 0 → 1. The pipeline loads the decode of pixel (0,0).
- Output alignment: `hsync_n`, `vsync_n` and `video_on` describe the pixel that `counter_x`/`counter_y` showed `SYNC_DELAY` enabled cycles earlier. This matches the colour controller's one-register latency at the default.
- Reset mid-frame: all outputs return to their reset values immediately. The frame restarts at (0,0). No partial sync pulse may extend past reset assertion.
- Simultaneous wrap: when the horizontal carry and `V_TOTAL-1` coincide, both counters go to 0 on the same edge.
- At defaults with `pix_en` held high:
  - line period = 800 cycles;
  - frame period = 420000 cycles;
  - hsync low for 96 consecutive cycles per line;
  - vsync low for 1600 consecutive cycles per frame.

## Structure
- Timing defaults and the phase encodings ACTIVE = 0, FRONT = 1, SYNC = 2, BACK = 3 go in the shared `constants.vh`, next to the field and paddle constants.
- One sub-module, `vga_axis_counter`, instantiated twice. It contains the counter, the phase FSM, carry-in and carry-out, and is parameterised by the four segment lengths.
- The top level holds the axis chaining, the delay pipeline and the strobes.

## Test plan
- Reset held for 5 cycles, then released, with `pix_en` = 1:
  - during reset the outputs are (0, 0, hsync_n = 1, vsync_n = 1, video_on = 0);
  - at the first edge after release `counter_x` = 1;
  - `video_on` = 1 from that cycle on.
- Run one line:
  - `hsync_n` falls exactly 1 cycle after `counter_x` = 656 and stays low for 96 cycles;
  - `line_end` is high only at `counter_x` = 799;
  - the next cycle shows `counter_x` = 0 and `counter_y` = 1.
- Run two full frames:
  - `frame_end` pulses are exactly 420000 cycles apart;
  - `vsync_n` is low for lines 490-491 only, delayed by 1 cycle;
  - `video_on` is high for exactly 307200 cycles per frame.
- `pix_en` toggling 1/0 every cycle (50 MHz mode):
  - the frame period becomes 840000 cycles;
  - all outputs hold during low-enable cycles;
  - no strobe is asserted while `pix_en` = 0.
- Assert reset at (700, 491), which is inside both sync pulses:
  - `hsync_n` and `vsync_n` go to 1 immediately;
  - after release the counters resume from 0, 1.
- Build with `SYNC_DELAY` = 0 and `SYNC_DELAY` = 3: the `hsync_n` falling edge follows `counter_x` = 656 by 0 and 3 cycles respectively.
